// File: rtl/prioritet_iterator.sv
// Sequential priority iterator: accepts a request vector and walks its set bits
// one beat at a time, highest (or lowest) index first, with popcount and beat index.
module prioritet_iterator #(
    parameter int DATA_W    = 16,
    parameter int POS_W     = $clog2(DATA_W),
    parameter int CNT_W     = $clog2(DATA_W + 1),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POS_W-1:0]  out_pos,
    output logic [POS_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_empty,
    output logic [CNT_W-1:0]  bit_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_r;
    logic [DATA_W-1:0]  shadow_r;
    logic [CNT_W-1:0]   bit_count_r;
    logic [POS_W-1:0]   out_idx_r;

    logic               scan_s;
    logic               empty_s;
    logic               one_hot_s;
    logic               last_s;
    logic               beat_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [POS_W-1:0]   enc_pos_s;
    logic [DATA_W-1:0]  clear_mask_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] d);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            c = c + CNT_W'(d[i]);
        end
        return c;
    endfunction

    // Later matches overwrite earlier ones, so scan order sets the winning end.
    function automatic logic [POS_W-1:0] prio_enc(input logic [DATA_W-1:0] d,
                                                  input logic msb_first);
        logic [POS_W-1:0] p;
        p = {POS_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            if (msb_first) begin
                p = d[i] ? POS_W'(i) : p;
            end else begin
                p = d[DATA_W-1-i] ? POS_W'(DATA_W - 1 - i) : p;
            end
        end
        return p;
    endfunction

    // Beat decode, handshakes and the mask that retires the current position.
    always_comb begin
        scan_s       = (state_r == SCAN);
        empty_s      = scan_s & (bit_count_r == {CNT_W{1'b0}});
        one_hot_s    = (shadow_r != {DATA_W{1'b0}}) &
                       ((shadow_r & (shadow_r - DATA_W'(1'b1))) == {DATA_W{1'b0}});
        last_s       = scan_s & (one_hot_s | empty_s);
        enc_pos_s    = scan_s ? prio_enc(shadow_r, MSB_FIRST) : {POS_W{1'b0}};
        clear_mask_s = DATA_W'(1'b1) << enc_pos_s;
        beat_s       = scan_s & out_ready;
        in_ready_s   = ~rst & (~scan_s | (beat_s & last_s));
        accept_s     = in_valid & in_ready_s;
    end

    // Vector capture, bit retirement and state sequencing; a new accept wins over the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shadow_r    <= {DATA_W{1'b0}};
            bit_count_r <= {CNT_W{1'b0}};
            out_idx_r   <= {POS_W{1'b0}};
        end else if (accept_s) begin
            state_r     <= SCAN;
            shadow_r    <= in_data;
            bit_count_r <= popcount(in_data);
            out_idx_r   <= {POS_W{1'b0}};
        end else if (beat_s) begin
            shadow_r <= shadow_r & ~clear_mask_s;
            if (last_s) begin
                state_r <= IDLE;
            end else begin
                out_idx_r <= out_idx_r + POS_W'(1'b1);
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = scan_s;
    assign out_pos   = enc_pos_s;
    assign out_idx   = out_idx_r;
    assign out_last  = last_s;
    assign out_empty = empty_s;
    assign bit_count = bit_count_r;

endmodule
